// File: rtl/lincomb_pipe.sv
// lincomb_pipe
//   Four-stage handshaked pipeline computing
//     e = sat(k0*a + k1*b + k2*c + k3*d)
//   with runtime-programmable signed coefficients. Each accepted sample
//   carries its own copy of the coefficients down the pipe, so coefficient
//   writes never disturb samples already in flight.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is combinational from out_ready
//   a, b, c, d          unsigned operands (W bits)
//   cfg_we/sel/data     coefficient write port (k[cfg_sel] <= cfg_data)
//   out_valid/out_ready output handshake
//   e                   signed saturated result (OW bits)
//   ovf, ovf_clr        sticky saturation flag and its clear (set wins)
//   s1, s2, s3          partial-sum registers of stages 1..3 (debug taps)
module lincomb_pipe #(
  parameter int W  = 8,
  parameter int CW = 6,
  parameter int OW = 16,
  localparam int ACC = W + CW + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [W-1:0]          c,
  input  logic [W-1:0]          d,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [CW-1:0]         cfg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [OW-1:0]  e,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic signed [ACC-1:0] s1,
  output logic signed [ACC-1:0] s2,
  output logic signed [ACC-1:0] s3
);

  // Operand zero-extended, coefficient sign-extended, product formed at the
  // full accumulator width so it is exact.
  function automatic logic signed [ACC-1:0] mul(input logic [W-1:0] x,
                                                input logic signed [CW-1:0] k);
    logic signed [ACC-1:0] xs;
    logic signed [ACC-1:0] ks;
    xs = $signed({{(ACC-W){1'b0}}, x});
    ks = {{(ACC-CW){k[CW-1]}}, k};
    return xs * ks;
  endfunction

  // Value fits in OW bits when all bits from the OW-1 position upward agree.
  function automatic logic out_of_range(input logic signed [ACC-1:0] x);
    return !((&x[ACC-1:OW-1]) || !(|x[ACC-1:OW-1]));
  endfunction

  function automatic logic signed [OW-1:0] sat(input logic signed [ACC-1:0] x);
    if (out_of_range(x)) begin
      return x[ACC-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
    return x[OW-1:0];
  endfunction

  logic signed [CW-1:0]  k_q [4];

  logic                  vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic                  ld1, ld2, ld3, ld4;

  logic signed [ACC-1:0] p1_q;
  logic [W-1:0]          b_p1_q, c_p1_q, d_p1_q;
  logic signed [CW-1:0]  k1_p1_q, k2_p1_q, k3_p1_q;

  logic signed [ACC-1:0] p2_q;
  logic [W-1:0]          c_p2_q, d_p2_q;
  logic signed [CW-1:0]  k2_p2_q, k3_p2_q;

  logic signed [ACC-1:0] p3_q;
  logic [W-1:0]          d_p3_q;
  logic signed [CW-1:0]  k3_p3_q;

  logic signed [OW-1:0]  e_q;
  logic                  ovf_q, ovf_d;
  logic signed [ACC-1:0] sum_d;

  // Load enables ripple back from the consumer so a full pipe drains with
  // no bubble: a stage may load when empty or when its successor loads.
  always_comb begin
    ld4 = !vld_p4_q || out_ready;
    ld3 = !vld_p3_q || ld4;
    ld2 = !vld_p2_q || ld3;
    ld1 = !vld_p1_q || ld2;
  end

  assign in_ready = ld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q[0] <= CW'(5);
      k_q[1] <= CW'(5);
      k_q[2] <= CW'(-4);
      k_q[3] <= CW'(3);
    end else if (cfg_we) begin
      k_q[cfg_sel] <= cfg_data;
    end
  end

  // Stage 1: k0*a, snapshot of k1..k3 taken from the pre-write register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      p1_q     <= '0;
      b_p1_q   <= '0;
      c_p1_q   <= '0;
      d_p1_q   <= '0;
      k1_p1_q  <= '0;
      k2_p1_q  <= '0;
      k3_p1_q  <= '0;
    end else if (ld1) begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        p1_q    <= mul(a, k_q[0]);
        b_p1_q  <= b;
        c_p1_q  <= c;
        d_p1_q  <= d;
        k1_p1_q <= k_q[1];
        k2_p1_q <= k_q[2];
        k3_p1_q <= k_q[3];
      end
    end
  end

  // Stage 2: + k1*b
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      p2_q     <= '0;
      c_p2_q   <= '0;
      d_p2_q   <= '0;
      k2_p2_q  <= '0;
      k3_p2_q  <= '0;
    end else if (ld2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        p2_q    <= p1_q + mul(b_p1_q, k1_p1_q);
        c_p2_q  <= c_p1_q;
        d_p2_q  <= d_p1_q;
        k2_p2_q <= k2_p1_q;
        k3_p2_q <= k3_p1_q;
      end
    end
  end

  // Stage 3: + k2*c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3_q <= 1'b0;
      p3_q     <= '0;
      d_p3_q   <= '0;
      k3_p3_q  <= '0;
    end else if (ld3) begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        p3_q    <= p2_q + mul(c_p2_q, k2_p2_q);
        d_p3_q  <= d_p2_q;
        k3_p3_q <= k3_p2_q;
      end
    end
  end

  // Stage 4: + k3*d, saturate into the output register
  always_comb begin
    sum_d = p3_q + mul(d_p3_q, k3_p3_q);
    ovf_d = (ovf_q && !ovf_clr) || (ld4 && vld_p3_q && out_of_range(sum_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p4_q <= 1'b0;
      e_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (ld4) begin
        vld_p4_q <= vld_p3_q;
        if (vld_p3_q) begin
          e_q <= sat(sum_d);
        end
      end
    end
  end

  assign out_valid = vld_p4_q;
  assign e         = e_q;
  assign ovf       = ovf_q;
  assign s1        = p1_q;
  assign s2        = p2_q;
  assign s3        = p3_q;

endmodule

// File: tb/tb_lincomb_pipe.sv
module tb_lincomb_pipe;
  localparam int CW   = 6;
  localparam int W0   = 10;
  localparam int OW0  = 16;
  localparam int ACC0 = W0 + CW + 3;
  localparam int W1   = 8;
  localparam int OW1  = 12;
  localparam int ACC1 = W1 + CW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (W=10 so D=768 is representable)
  logic                   in_valid0, in_ready0, cfg_we0, out_valid0, out_ready0, ovf0, ovf_clr0;
  logic [W0-1:0]          a0, b0, c0, d0;
  logic [1:0]             cfg_sel0;
  logic [CW-1:0]          cfg_data0;
  logic signed [OW0-1:0]  e0;
  logic signed [ACC0-1:0] s1_0, s2_0, s3_0;

  // narrow-output instance for saturation
  logic                   in_valid1, in_ready1, cfg_we1, out_valid1, out_ready1, ovf1, ovf_clr1;
  logic [W1-1:0]          a1, b1, c1, d1;
  logic [1:0]             cfg_sel1;
  logic [CW-1:0]          cfg_data1;
  logic signed [OW1-1:0]  e1;
  logic signed [ACC1-1:0] s1_1, s2_1, s3_1;

  lincomb_pipe #(.W(W0), .CW(CW), .OW(OW0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .cfg_we(cfg_we0), .cfg_sel(cfg_sel0), .cfg_data(cfg_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .e(e0),
    .ovf(ovf0), .ovf_clr(ovf_clr0), .s1(s1_0), .s2(s2_0), .s3(s3_0));

  lincomb_pipe #(.W(W1), .CW(CW), .OW(OW1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .cfg_we(cfg_we1), .cfg_sel(cfg_sel1), .cfg_data(cfg_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .e(e1),
    .ovf(ovf1), .ovf_clr(ovf_clr1), .s1(s1_1), .s2(s2_1), .s3(s3_1));

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int mk0[4] = '{5, 5, -4, 3};
  int mk1[4] = '{5, 5, -4, 3};
  int pop_cnt0 = 0;
  int acc_cnt0 = 0;
  logic stall0 = 1'b0;
  longint e_prev0 = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int calc(input int av, input int bv, input int cv, input int dv,
                              input int k0, input int k1, input int k2, input int k3,
                              input int ow);
    longint s, mx;
    s  = longint'(k0) * av + longint'(k1) * bv + longint'(k2) * cv + longint'(k3) * dv;
    mx = (64'sd1 <<< (ow - 1)) - 1;
    if (s > mx) return int'(mx);
    if (s < -mx - 1) return int'(-mx - 1);
    return int'(s);
  endfunction

  // Scoreboard for the main instance: pops on every output handshake,
  // checks hold-during-stall, pushes a model result on every accept.
  always @(negedge clk) begin : mon0
    int ev;
    #2;
    if (rst) begin
      q0.delete();
      mk0 = '{5, 5, -4, 3};
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        chk("stall_hold_valid", out_valid0, 1);
        chk("stall_hold_e", e0, e_prev0);
      end
      if (out_valid0 && out_ready0) begin
        pop_cnt0++;
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out0: got e=%0d expected no output", e0);
        end else begin
          ev = q0.pop_front();
          chk("e0_scoreboard", e0, ev);
        end
      end
      stall0  = out_valid0 && !out_ready0;
      e_prev0 = e0;
      if (in_valid0 && in_ready0) begin
        q0.push_back(calc(a0, b0, c0, d0, mk0[0], mk0[1], mk0[2], mk0[3], OW0));
        acc_cnt0++;
      end
      if (cfg_we0) mk0[cfg_sel0] = int'($signed(cfg_data0));
    end
  end

  always @(negedge clk) begin : mon1
    int ev;
    #2;
    if (rst) begin
      q1.delete();
      mk1 = '{5, 5, -4, 3};
    end else begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out1: got e=%0d expected no output", e1);
        end else begin
          ev = q1.pop_front();
          chk("e1_scoreboard", e1, ev);
        end
      end
      if (in_valid1 && in_ready1)
        q1.push_back(calc(a1, b1, c1, d1, mk1[0], mk1[1], mk1[2], mk1[3], OW1));
      if (cfg_we1) mk1[cfg_sel1] = int'($signed(cfg_data1));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int acc_base, pop_base;
    in_valid0 = 0; a0 = 0; b0 = 0; c0 = 0; d0 = 0;
    cfg_we0 = 0; cfg_sel0 = 0; cfg_data0 = 0; out_ready0 = 1; ovf_clr0 = 0;
    in_valid1 = 0; a1 = 0; b1 = 0; c1 = 0; d1 = 0;
    cfg_we1 = 0; cfg_sel1 = 0; cfg_data1 = 0; out_ready1 = 1; ovf_clr1 = 0;

    // reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_e", e0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_s1", s1_0, 0);
    @(negedge clk);
    rst = 0;

    // single shot with default coefficients
    @(negedge clk);
    a0 = 10; b0 = 20; c0 = 5; d0 = 768; in_valid0 = 1;
    @(negedge clk);
    in_valid0 = 0;
    #2 chk("s1_single", s1_0, 50);
    @(negedge clk);
    #2 chk("s2_single", s2_0, 150);
    @(negedge clk);
    #2 chk("s3_single", s3_0, 130);
    chk("latency_not_early", out_valid0, 0);
    @(negedge clk);
    #2 chk("latency_valid", out_valid0, 1);
    chk("e_single", e0, 2434);

    // 16 back-to-back samples, full throughput
    @(negedge clk);
    pop_base = pop_cnt0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a0 = W0'($urandom_range(0, 1023)); b0 = W0'($urandom_range(0, 1023));
      c0 = W0'($urandom_range(0, 1023)); d0 = W0'($urandom_range(0, 1023));
      in_valid0 = 1;
      #2 chk("in_ready_b2b", in_ready0, 1);
    end
    @(negedge clk);
    in_valid0 = 0;
    repeat (6) @(negedge clk);
    #3 chk("b2b_result_count", pop_cnt0 - pop_base, 16);

    // stall with out_ready held low: four accepts then in_ready drops
    @(negedge clk);
    out_ready0 = 0;
    acc_base = acc_cnt0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      a0 = W0'($urandom_range(0, 255)); b0 = W0'($urandom_range(0, 255));
      c0 = W0'($urandom_range(0, 255)); d0 = W0'($urandom_range(0, 255));
      in_valid0 = 1;
    end
    #3 chk("stall_in_ready", in_ready0, 0);
    chk("stall_accepts", acc_cnt0 - acc_base, 4);

    // random backpressure stream
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      out_ready0 = 1'($urandom_range(0, 1));
      in_valid0  = 1'($urandom_range(0, 1));
      a0 = W0'($urandom_range(0, 1023)); b0 = W0'($urandom_range(0, 1023));
      c0 = W0'($urandom_range(0, 1023)); d0 = W0'($urandom_range(0, 1023));
    end
    @(negedge clk);
    in_valid0 = 0; out_ready0 = 1;
    repeat (8) @(negedge clk);
    #3 chk("stream_drained", q0.size(), 0);

    // coefficient write in the accept cycle uses the old value
    @(negedge clk);
    cfg_we0 = 1; cfg_sel0 = 0; cfg_data0 = 6'b100000;
    a0 = 1; b0 = 0; c0 = 0; d0 = 0; in_valid0 = 1;
    @(negedge clk);
    cfg_we0 = 0;
    @(negedge clk);
    a0 = 0;
    @(negedge clk);
    in_valid0 = 0;
    @(negedge clk);
    #2 chk("snap_old_k0", e0, 5);
    @(negedge clk);
    #2 chk("snap_new_k0", e0, -32);
    @(negedge clk);
    #2 chk("zero_sample", e0, 0);

    // saturation and sticky ovf on the OW=12 instance
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      cfg_we1 = 1; cfg_sel1 = 2'(s); cfg_data1 = 6'd31;
    end
    @(negedge clk);
    cfg_we1 = 0; a1 = 255; b1 = 255; c1 = 255; d1 = 255; in_valid1 = 1;
    @(negedge clk);
    a1 = 1; b1 = 0; c1 = 0; d1 = 0;
    @(negedge clk);
    in_valid1 = 0;
    @(negedge clk);
    @(negedge clk);
    #2 chk("sat_pos_e", e1, 2047);
    chk("sat_pos_ovf", ovf1, 1);
    @(negedge clk);
    #2 chk("nonsat_e", e1, 31);
    chk("ovf_sticky", ovf1, 1);
    @(negedge clk);
    ovf_clr1 = 1;
    @(negedge clk);
    ovf_clr1 = 0;
    #2 chk("ovf_cleared", ovf1, 0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      cfg_we1 = 1; cfg_sel1 = 2'(s); cfg_data1 = 6'b100000;
    end
    @(negedge clk);
    cfg_we1 = 0; a1 = 255; b1 = 255; c1 = 255; d1 = 255; in_valid1 = 1;
    @(negedge clk);
    in_valid1 = 0;
    repeat (3) @(negedge clk);
    #2 chk("sat_neg_e", e1, -2048);
    chk("sat_neg_ovf", ovf1, 1);

    // saturate the main instance, then reset with three samples in flight
    @(negedge clk);
    cfg_we0 = 1; cfg_sel0 = 0; cfg_data0 = 6'd31;
    @(negedge clk);
    cfg_sel0 = 1;
    @(negedge clk);
    cfg_we0 = 0; a0 = 1023; b0 = 1023; c0 = 0; d0 = 0; in_valid0 = 1;
    @(negedge clk);
    in_valid0 = 0;
    repeat (5) @(negedge clk);
    #2 chk("main_ovf_set", ovf0, 1);
    chk("main_sat_e", e0, 32767);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a0 = 10'(i + 1); b0 = 0; c0 = 0; d0 = 0; in_valid0 = 1;
    end
    @(negedge clk);
    in_valid0 = 0;
    rst = 1;
    #1 chk("rst_flight_out_valid", out_valid0, 0);
    chk("rst_flight_e", e0, 0);
    chk("rst_flight_ovf", ovf0, 0);
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);

    // coefficients back to defaults
    @(negedge clk);
    a0 = 10; b0 = 20; c0 = 5; d0 = 768; in_valid0 = 1;
    @(negedge clk);
    in_valid0 = 0;
    repeat (3) @(negedge clk);
    #2 chk("post_rst_valid", out_valid0, 1);
    chk("post_rst_default_k", e0, 2434);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
